// File: rtl/seq_pkg.sv
// Shared definitions for the arbitrary-sequence counter and its checker:
// the fixed 7-entry sequence table, FSM state type and index helper.
package seq_pkg;

  localparam int SEQ_LEN = 7;
  localparam int SEQ_DW  = 4;

  localparam logic [SEQ_DW-1:0] SEQ_TABLE [SEQ_LEN] =
    '{4'd2, 4'd9, 4'd4, 4'd1, 4'd6, 4'd3, 4'd8};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } seq_state_e;

  function automatic logic [2:0] seq_nxt(input logic [2:0] i);
    return (i == 3'(SEQ_LEN - 1)) ? 3'd0 : i + 3'd1;
  endfunction

endpackage

// File: rtl/seq_lookup.sv
// Combinational reverse lookup: sample value -> position in SEQ_TABLE.
module seq_lookup
  import seq_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0] in_data,
  output logic [2:0]    idx,
  output logic          found
);

  // Table entries are unique, so at most one position can hit.
  always_comb begin
    idx   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (in_data == DW'(SEQ_TABLE[i])) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Sequence monitor: hunts for, locks onto and flags deviations from the
// 2,9,4,1,6,3,8 cycle. Optional capture of the last bad sample: SEQ_CHK_CAPTURE_EN.
module seq_checker
  import seq_pkg::*;
#(
  parameter int DW         = 4,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERRW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic            clr_err,
  output logic            locked,
  output logic            mismatch,
  output logic [DW-1:0]   exp_data,
  output logic [2:0]      pos,
  output logic [ERRW-1:0] err_count
`ifdef SEQ_CHK_CAPTURE_EN
  ,
  output logic [DW-1:0]   last_bad_data,
  output logic [DW-1:0]   last_bad_exp
`endif
);

  seq_state_e      state_q, state_d;
  logic [2:0]      pos_q, pos_d;
  logic [2:0]      run_q, run_d;
  logic [2:0]      miss_q, miss_d;
  logic            mismatch_q, mismatch_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [ERRW-1:0] err_base;
  logic [DW-1:0]   exp_cur;
  logic [2:0]      lk_idx;
  logic            lk_found;
  logic            hit;

  seq_lookup #(.DW(DW)) u_lookup (
    .in_data (in_data),
    .idx     (lk_idx),
    .found   (lk_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      pos_q      <= 3'd0;
      run_q      <= 3'd0;
      miss_q     <= 3'd0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      run_q      <= run_d;
      miss_q     <= miss_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    run_d      = run_q;
    miss_d     = miss_q;
    mismatch_d = 1'b0;
    err_base   = clr_err ? '0 : err_q;
    err_d      = err_base;
    hit        = (in_data == exp_cur);

    if (in_valid) begin
      if (state_q == LOCKED) begin
        pos_d = seq_nxt(pos_q);
        if (hit) begin
          miss_d = 3'd0;
        end else begin
          mismatch_d = 1'b1;
          err_d      = (&err_base) ? err_base : err_base + ERRW'(1);
          miss_d     = miss_q + 3'd1;
          if (miss_d == 3'(UNLOCK_CNT)) begin
            state_d = HUNT;
            pos_d   = 3'd0;
            run_d   = 3'd0;
            miss_d  = 3'd0;
          end
        end
      end else if (state_q == VERIFY && hit) begin
        pos_d = seq_nxt(pos_q);
        run_d = run_q + 3'd1;
        if (run_d == 3'(LOCK_CNT)) begin
          state_d = LOCKED;
          miss_d  = 3'd0;
        end
      end else begin
        // HUNT, or a VERIFY miss re-hunting on the very same sample
        miss_d = 3'd0;
        if (lk_found) begin
          pos_d   = seq_nxt(lk_idx);
          run_d   = 3'd1;
          state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end else begin
          state_d = HUNT;
          pos_d   = 3'd0;
          run_d   = 3'd0;
        end
      end
    end
  end

  always_comb begin
    exp_cur   = (state_q == HUNT) ? '0 : DW'(SEQ_TABLE[pos_q]);
    locked    = (state_q == LOCKED);
    exp_data  = exp_cur;
    pos       = pos_q;
    mismatch  = mismatch_q;
    err_count = err_q;
  end

`ifdef SEQ_CHK_CAPTURE_EN
  logic [DW-1:0] bad_data_q, bad_data_d;
  logic [DW-1:0] bad_exp_q, bad_exp_d;

  // A capture in the same cycle as clr_err wins, like the error count.
  always_comb begin
    bad_data_d = clr_err ? '0 : bad_data_q;
    bad_exp_d  = clr_err ? '0 : bad_exp_q;
    if (mismatch_d) begin
      bad_data_d = in_data;
      bad_exp_d  = exp_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bad_data_q <= '0;
      bad_exp_q  <= '0;
    end else begin
      bad_data_q <= bad_data_d;
      bad_exp_q  <= bad_exp_d;
    end
  end

  assign last_bad_data = bad_data_q;
  assign last_bad_exp  = bad_exp_q;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed scenarios plus a randomized
// stream, compared every cycle against a behavioural model of the lock rules.
`timescale 1ns/1ps
module tb_seq_checker;

  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       clr_err;

  logic       locked, mismatch;
  logic [3:0] exp_data;
  logic [2:0] pos;
  logic [7:0] err_count;

  logic       s_locked, s_mismatch;
  logic [3:0] s_exp_data;
  logic [2:0] s_pos;
  logic [1:0] s_err_count;

`ifdef SEQ_CHK_CAPTURE_EN
  logic [3:0] lb_data, lb_exp, s_lb_data, s_lb_exp;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  int tbl [7] = '{2, 9, 4, 1, 6, 3, 8};

  // model: mode 0 = hunting, 1 = verifying, 2 = locked
  int m_mode = 0, m_pos = 0, m_run = 0, m_miss = 0;
  int m_err = 0, m_err2 = 0, m_mm = 0;
  int m_bd = 0, m_be = 0;

  seq_checker #(.DW(4), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERRW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked), .mismatch(mismatch), .exp_data(exp_data), .pos(pos),
    .err_count(err_count)
`ifdef SEQ_CHK_CAPTURE_EN
    , .last_bad_data(lb_data), .last_bad_exp(lb_exp)
`endif
  );

  seq_checker #(.DW(4), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERRW(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(s_locked), .mismatch(s_mismatch), .exp_data(s_exp_data), .pos(s_pos),
    .err_count(s_err_count)
`ifdef SEQ_CHK_CAPTURE_EN
    , .last_bad_data(s_lb_data), .last_bad_exp(s_lb_exp)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running exp finished");
    $fatal(1);
  end

  function automatic int find_idx(input int v);
    for (int i = 0; i < 7; i++) if (tbl[i] == v) return i;
    return -1;
  endfunction

  function automatic int m_exp();
    return (m_mode == 0) ? 0 : tbl[m_pos];
  endfunction

  task automatic model_step(input bit r, input bit v, input int d, input bit c);
    int e, k;
    if (r) begin
      m_mode = 0; m_pos = 0; m_run = 0; m_miss = 0;
      m_err = 0; m_err2 = 0; m_mm = 0; m_bd = 0; m_be = 0;
      return;
    end
    m_mm = 0;
    if (c) begin m_err = 0; m_err2 = 0; m_bd = 0; m_be = 0; end
    if (!v) return;
    e = m_exp();
    if (m_mode == 2) begin
      m_pos = (m_pos + 1) % 7;
      if (d == e) m_miss = 0;
      else begin
        m_mm = 1;
        m_bd = d; m_be = e;
        m_err  = (m_err  >= 255) ? 255 : m_err + 1;
        m_err2 = (m_err2 >= 3)   ? 3   : m_err2 + 1;
        m_miss++;
        if (m_miss == UNLOCK_CNT) begin
          m_mode = 0; m_pos = 0; m_run = 0; m_miss = 0;
        end
      end
    end else if (m_mode == 1 && d == e) begin
      m_pos = (m_pos + 1) % 7;
      m_run++;
      if (m_run == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
    end else begin
      k = find_idx(d);
      if (k >= 0) begin
        m_pos = (k + 1) % 7; m_run = 1;
        m_mode = (LOCK_CNT == 1) ? 2 : 1;
      end else begin
        m_mode = 0; m_pos = 0; m_run = 0;
      end
    end
  endtask

  // One clock: drive, advance the model on the edge, compare on the falling edge.
  task automatic cyc(input bit v, input int d, input bit c, input bit r);
    rst = r; in_valid = v; in_data = 4'(d); clr_err = c;
    @(posedge clk);
    model_step(r, v, d, c);
    @(negedge clk);
    n_chk++;
    if (locked !== (m_mode == 2)) $display("FAIL sb_locked got %0b exp %0b", locked, (m_mode == 2));
    else n_pass++;
    n_chk++;
    if (mismatch !== 1'(m_mm)) $display("FAIL sb_mismatch got %0b exp %0d", mismatch, m_mm);
    else n_pass++;
    n_chk++;
    if (exp_data !== 4'(m_exp())) $display("FAIL sb_exp_data got %0d exp %0d", exp_data, m_exp());
    else n_pass++;
    n_chk++;
    if (pos !== 3'(m_pos)) $display("FAIL sb_pos got %0d exp %0d", pos, m_pos);
    else n_pass++;
    n_chk++;
    if (err_count !== 8'(m_err)) $display("FAIL sb_err_count got %0d exp %0d", err_count, m_err);
    else n_pass++;
    n_chk++;
    if ({s_locked, s_mismatch, s_exp_data, s_pos, s_err_count} !==
        {(m_mode == 2), 1'(m_mm), 4'(m_exp()), 3'(m_pos), 2'(m_err2)})
      $display("FAIL sb_errw2 got %0b/%0b/%0d/%0d/%0d exp %0b/%0d/%0d/%0d/%0d",
               s_locked, s_mismatch, s_exp_data, s_pos, s_err_count,
               (m_mode == 2), m_mm, m_exp(), m_pos, m_err2);
    else n_pass++;
`ifdef SEQ_CHK_CAPTURE_EN
    n_chk++;
    if ({lb_data, lb_exp, s_lb_data, s_lb_exp} !== {4'(m_bd), 4'(m_be), 4'(m_bd), 4'(m_be)})
      $display("FAIL sb_capture got %0d/%0d exp %0d/%0d", lb_data, lb_exp, m_bd, m_be);
    else n_pass++;
`endif
  endtask

  task automatic feed(input int a, input int b, input int c3);
    cyc(1, a, 0, 0); cyc(1, b, 0, 0); cyc(1, c3, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
    n_chk++;
    if ({locked, mismatch, exp_data, pos, err_count} !== 17'd0)
      $display("FAIL reset_outputs got %0b/%0b/%0d/%0d/%0d exp all 0",
               locked, mismatch, exp_data, pos, err_count);
    else n_pass++;
  endtask

  task automatic test_lock_on();
    cyc(1, 2, 0, 0); cyc(1, 9, 0, 0);
    n_chk++;
    if (locked !== 1'b0) $display("FAIL lock_early got %0b exp 0", locked); else n_pass++;
    cyc(1, 4, 0, 0);
    n_chk++;
    if ({locked, exp_data, err_count} !== {1'b1, 4'd1, 8'd0})
      $display("FAIL lock_on got %0b/%0d/%0d exp 1/1/0", locked, exp_data, err_count);
    else n_pass++;
  endtask

  task automatic test_mid_entry();
    cyc(1, 0, 0, 1);
    feed(6, 3, 8);
    n_chk++;
    if ({locked, exp_data, pos} !== {1'b1, 4'd2, 3'd0})
      $display("FAIL mid_entry got %0b/%0d/%0d exp 1/2/0", locked, exp_data, pos);
    else n_pass++;
    cyc(1, 2, 0, 0);
    n_chk++;
    if ({locked, mismatch} !== 2'b10)
      $display("FAIL wrap_match got %0b/%0b exp 1/0", locked, mismatch);
    else n_pass++;
  endtask

  task automatic test_glitch();
    cyc(1, 0, 0, 1);
    feed(2, 9, 4); cyc(1, 1, 0, 0); cyc(1, 7, 0, 0);
    n_chk++;
    if ({mismatch, locked, err_count, exp_data} !== {1'b1, 1'b1, 8'd1, 4'd3})
      $display("FAIL glitch got %0b/%0b/%0d/%0d exp 1/1/1/3", mismatch, locked, err_count, exp_data);
    else n_pass++;
    cyc(1, 3, 0, 0); cyc(1, 8, 0, 0);
    n_chk++;
    if ({mismatch, locked, err_count} !== {1'b0, 1'b1, 8'd1})
      $display("FAIL glitch_recover got %0b/%0b/%0d exp 0/1/1", mismatch, locked, err_count);
    else n_pass++;
  endtask

  task automatic test_unlock();
    cyc(1, 5, 0, 0);
    n_chk++;
    if ({mismatch, locked, err_count} !== {1'b1, 1'b1, 8'd2})
      $display("FAIL unlock_first got %0b/%0b/%0d exp 1/1/2", mismatch, locked, err_count);
    else n_pass++;
    cyc(1, 5, 0, 0);
    n_chk++;
    if ({mismatch, locked, err_count, pos, exp_data} !== {1'b1, 1'b0, 8'd3, 3'd0, 4'd0})
      $display("FAIL unlock got %0b/%0b/%0d/%0d/%0d exp 1/0/3/0/0",
               mismatch, locked, err_count, pos, exp_data);
    else n_pass++;
  endtask

  task automatic test_saturation();
    cyc(1, 0, 0, 1);
    for (int r = 0; r < 3; r++) begin
      feed(2, 9, 4); cyc(1, 5, 0, 0); cyc(1, 5, 0, 0);
    end
    n_chk++;
    if ({s_err_count, err_count} !== {2'd3, 8'd6})
      $display("FAIL saturate got %0d/%0d exp 3/6", s_err_count, err_count);
    else n_pass++;
    feed(2, 9, 4);
    cyc(1, 5, 1, 0);
    n_chk++;
    if ({s_err_count, err_count, mismatch} !== {2'd1, 8'd1, 1'b1})
      $display("FAIL clr_with_mismatch got %0d/%0d/%0b exp 1/1/1", s_err_count, err_count, mismatch);
    else n_pass++;
    cyc(0, 0, 1, 0);
    n_chk++;
    if (err_count !== 8'd0) $display("FAIL clr_only got %0d exp 0", err_count); else n_pass++;
  endtask

  task automatic test_gaps();
    cyc(1, 0, 0, 1);
    cyc(1, 2, 0, 0); cyc(0, 7, 0, 0); cyc(1, 9, 0, 0); cyc(0, 5, 0, 0);
    n_chk++;
    if ({locked, mismatch, pos} !== {1'b0, 1'b0, 3'd2})
      $display("FAIL gap_hold got %0b/%0b/%0d exp 0/0/2", locked, mismatch, pos);
    else n_pass++;
    cyc(1, 4, 0, 0); cyc(0, 0, 0, 0);
    n_chk++;
    if ({locked, mismatch, exp_data} !== {1'b1, 1'b0, 4'd1})
      $display("FAIL gap_lock got %0b/%0b/%0d exp 1/0/1", locked, mismatch, exp_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cyc(1, 5, 0, 0);
    cyc(1, 5, 0, 1);
    n_chk++;
    if ({locked, mismatch, exp_data, pos, err_count} !== 17'd0)
      $display("FAIL reset_mid got %0b/%0b/%0d/%0d/%0d exp all 0",
               locked, mismatch, exp_data, pos, err_count);
    else n_pass++;
  endtask

  task automatic test_random();
    int p = $urandom_range(0, 6);
    for (int i = 0; i < 2500; i++) begin
      bit v = ($urandom_range(0, 9) < 8);
      bit c = ($urandom_range(0, 49) == 0);
      bit r = ($urandom_range(0, 199) == 0);
      int d;
      if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 15);
      else d = tbl[p];
      if ($urandom_range(0, 99) == 0) p = $urandom_range(0, 6);
      if (v) p = (p + 1) % 7;
      cyc(v, d, c, r);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; clr_err = 1'b0;
    test_reset();
    test_lock_on();
    test_mid_entry();
    test_glitch();
    test_unlock();
    test_saturation();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
